fetch_sequencer: RTL

//  Sequences the combinational-read instruction memory for the CPU front end.
//  - Holds the program counter and drives the memory address.
//  - Captures each fetched word into an instruction register and offers it to decode on a valid/ready handshake.
//  - Applies branch redirects from execute, and stops fetching once a HLT instruction has been accepted.

---
 rtl/fetch_sequencer_if.sv | 47 ++++
 rtl/fetch_sequencer.sv | 119 +++++++++++
 2 files changed

// File: rtl/fetch_sequencer_if.sv
// Fetch-to-environment bundle: instruction memory port, decode handshake,
// branch redirect and status. master = sequencer side, slave = memory/decode/execute side.
interface fetch_sequencer_if #(
    parameter int unsigned INSTRUCTION_SIZE      = 16,
    parameter int unsigned INSTRUCTION_ADDR_SIZE = 10,
    parameter int unsigned COUNT_WIDTH           = 16
);
    logic                             start;
    logic [INSTRUCTION_ADDR_SIZE-1:0] imem_addr;
    logic [INSTRUCTION_SIZE-1:0]      imem_data;
    logic [INSTRUCTION_SIZE-1:0]      instr;
    logic                             instr_valid;
    logic                             instr_ready;
    logic                             redirect;
    logic [INSTRUCTION_ADDR_SIZE-1:0] redirect_addr;
    logic [INSTRUCTION_ADDR_SIZE-1:0] pc;
    logic                             halted;
    logic [COUNT_WIDTH-1:0]           instr_count;

    modport master (
        input  start,
        input  imem_data,
        input  instr_ready,
        input  redirect,
        input  redirect_addr,
        output imem_addr,
        output instr,
        output instr_valid,
        output pc,
        output halted,
        output instr_count
    );

    modport slave (
        output start,
        output imem_data,
        output instr_ready,
        output redirect,
        output redirect_addr,
        input  imem_addr,
        input  instr,
        input  instr_valid,
        input  pc,
        input  halted,
        input  instr_count
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: owns the PC, reads a combinational instruction
// memory, presents words to decode on valid/ready, handles redirects and HLT.
module fetch_sequencer #(
    parameter int unsigned INSTRUCTION_SIZE      = 16,
    parameter int unsigned INSTRUCTION_ADDR_SIZE = 10,
    parameter logic [3:0]  HLT_OPCODE            = 4'b0001,
    parameter int unsigned COUNT_WIDTH           = 16
) (
    input logic               clk,
    input logic               rst,
    fetch_sequencer_if.master bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_HALTED
    } state_e;

    state_e                           state_q, state_d;
    logic [INSTRUCTION_ADDR_SIZE-1:0] pc_q, pc_d;
    logic [INSTRUCTION_SIZE-1:0]      instr_q, instr_d;
    logic                             valid_q, valid_d;
    logic                             halted_q, halted_d;
    logic [COUNT_WIDTH-1:0]           count_q, count_d;

    logic xfer;
    logic is_hlt;

    assign xfer   = valid_q && bus.instr_ready;
    assign is_hlt = (instr_q[INSTRUCTION_SIZE-1 -: 4] == HLT_OPCODE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            pc_q     <= '0;
            instr_q  <= '0;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            valid_q  <= valid_d;
            halted_q <= halted_d;
            count_q  <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (bus.start) state_d = S_FETCH;
            S_FETCH:  state_d = bus.redirect ? S_FETCH : S_ISSUE;
            S_ISSUE: begin
                if (bus.redirect)       state_d = S_FETCH;
                else if (xfer && is_hlt) state_d = S_HALTED;
            end
            S_HALTED: if (bus.start) state_d = S_FETCH;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        pc_d     = pc_q;
        instr_d  = instr_q;
        valid_d  = valid_q;
        halted_d = halted_q;
        count_d  = count_q;
        unique case (state_q)
            S_IDLE, S_HALTED: begin
                if (bus.start) begin
                    pc_d     = '0;
                    count_d  = '0;
                    halted_d = 1'b0;
                end
            end
            S_FETCH: begin
                if (bus.redirect) begin
                    pc_d    = bus.redirect_addr;
                    valid_d = 1'b0;
                end else begin
                    instr_d = bus.imem_data;
                    valid_d = 1'b1;
                    pc_d    = pc_q + 1'b1;
                end
            end
            S_ISSUE: begin
                // Redirect wins over a same-cycle handshake: the transfer is squashed.
                if (bus.redirect) begin
                    pc_d    = bus.redirect_addr;
                    valid_d = 1'b0;
                end else if (xfer) begin
                    count_d = (&count_q) ? count_q : count_q + 1'b1;
                    if (is_hlt) begin
                        valid_d  = 1'b0;
                        halted_d = 1'b1;
                    end else begin
                        instr_d = bus.imem_data;
                        pc_d    = pc_q + 1'b1;
                    end
                end
            end
            default: begin
                valid_d = 1'b0;
            end
        endcase
    end

    assign bus.imem_addr   = pc_q;
    assign bus.pc          = pc_q;
    assign bus.instr       = instr_q;
    assign bus.instr_valid = valid_q;
    assign bus.halted      = halted_q;
    assign bus.instr_count = count_q;

endmodule
